// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
//   state_t  : loader FSM states
//   ERR_*    : load_error codes reported to the system
package imem_loader_pkg;

  typedef enum logic [2:0] {
    HDR,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in plus instruction-memory write port out.
//   rx_data/rx_valid/rx_ready : byte stream; a byte transfers on a rising
//                               clk edge where rx_valid && rx_ready. The
//                               source holds rx_data stable while rx_valid
//                               is high and the byte is not yet accepted.
//   imem_we/imem_addr/imem_wdata : one-cycle write strobe with word address
//                               and data.
//   master : byte source / memory side
//   slave  : loader side
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs accepted bytes, least significant first, into 32-bit words.
//   clk, reset  : clock, asynchronous active-high reset
//   clear       : synchronous return to lane 0 with an empty accumulator
//   byte_valid  : a byte is accepted this cycle
//   byte_data   : the accepted byte
//   word        : completed word, valid while word_valid is high
//   word_valid  : combinational pulse on the cycle the 4th byte is accepted
//   lane        : current byte lane (debug visibility)
module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid,
  output logic [1:0]  lane
);

  // Only the lower three lanes need storage; lane 3 comes straight from
  // the incoming byte so the word is available in the accepting cycle.
  logic [23:0] low_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane  <= 2'd0;
      low_q <= 24'd0;
    end else if (clear) begin
      lane  <= 2'd0;
      low_q <= 24'd0;
    end else if (byte_valid) begin
      case (lane)
        2'd0:    low_q[7:0]   <= byte_data;
        2'd1:    low_q[15:8]  <= byte_data;
        2'd2:    low_q[23:16] <= byte_data;
        default: low_q        <= low_q;
      endcase
      lane <= lane + 2'd1;
    end
  end

  assign word       = {byte_data, low_q};
  assign word_valid = byte_valid && (lane == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives LEN / DATA / CSUM frame over the byte stream,
// writes the words into instruction memory, verifies the checksum and
// then releases the core from reset.
//   clk, reset   : clock, asynchronous active-high reset
//   bus          : byte stream in, instruction-memory write port out
//   load_req     : restart request, honoured in DONE or ERR only
//   core_reset   : held high unless a load completed with a good checksum
//   load_done    : program loaded and checksum OK
//   load_error   : ERR_* code of the last failed load
//   words_loaded : number of words written in the current load
//   dbg_state    : current FSM state
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH          = 256,
  parameter int ADDR_W         = $clog2(DEPTH),
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic            clk,
  input  logic            reset,
  imem_loader_if.slave    bus,
  input  logic            load_req,
  output logic            core_reset,
  output logic            load_done,
  output logic [1:0]      load_error,
  output logic [ADDR_W:0] words_loaded,
  output state_t          dbg_state
);

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [1:0]    err_d;
  logic          accept, restart, active, tmo_hit;
  logic [31:0]   asm_word;
  logic          asm_valid;
  logic [1:0]    asm_lane;
  logic [ADDR_W:0] n_q;
  logic [31:0]   csum_q;
  logic [31:0]   tmo_cnt;
  logic          mid_frame;

  assign active       = (state_q == HDR) || (state_q == DATA) || (state_q == CSUM);
  assign bus.rx_ready = active;
  assign accept       = bus.rx_valid && active;
  assign restart      = load_req && !active;
  assign dbg_state    = state_q;

  word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (restart),
    .byte_valid (accept),
    .byte_data  (bus.rx_data),
    .word       (asm_word),
    .word_valid (asm_valid),
    .lane       (asm_lane)
  );

  // The idle counter only runs once a frame has started, so a loader
  // parked in HDR waiting for its first byte never times out.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && active && mid_frame && !accept &&
                   (tmo_cnt == TMO_LAST);

  always_comb begin
    state_d = state_q;
    err_d   = load_error;
    case (state_q)
      HDR: begin
        if (asm_valid) begin
          if (asm_word > 32'(DEPTH)) begin
            state_d = ERR;
            err_d   = ERR_LEN;
          end else if (asm_word == 32'd0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (asm_valid && ((words_loaded + 1'b1) == n_q)) state_d = CSUM;
      end
      CSUM: begin
        if (asm_valid) begin
          if (asm_word == csum_q) begin
            state_d = DONE;
          end else begin
            state_d = ERR;
            err_d   = ERR_CSUM;
          end
        end
      end
      DONE, ERR: begin
        if (load_req) begin
          state_d = HDR;
          err_d   = ERR_NONE;
        end
      end
      default: state_d = HDR;
    endcase
    if (tmo_hit) begin
      state_d = ERR;
      err_d   = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= HDR;
      load_error     <= ERR_NONE;
      core_reset     <= 1'b1;
      load_done      <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= 32'd0;
      words_loaded   <= '0;
      n_q            <= '0;
      csum_q         <= 32'd0;
      tmo_cnt        <= 32'd0;
      mid_frame      <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_error  <= err_d;
      core_reset  <= (state_d != DONE);
      load_done   <= (state_d == DONE);
      bus.imem_we <= 1'b0;
      if (restart) begin
        words_loaded <= '0;
        n_q          <= '0;
        csum_q       <= 32'd0;
        tmo_cnt      <= 32'd0;
        mid_frame    <= 1'b0;
      end else begin
        // Only lengths <= DEPTH are ever used, which fit in ADDR_W+1 bits.
        if ((state_q == HDR) && asm_valid) n_q <= asm_word[ADDR_W:0];
        if ((state_q == DATA) && asm_valid) begin
          bus.imem_we    <= 1'b1;
          bus.imem_addr  <= words_loaded[ADDR_W-1:0];
          bus.imem_wdata <= asm_word;
          words_loaded   <= words_loaded + 1'b1;
          csum_q         <= csum_q + asm_word;
        end
        if (accept) begin
          tmo_cnt   <= 32'd0;
          mid_frame <= 1'b1;
        end else if (active && mid_frame) begin
          tmo_cnt <= tmo_cnt + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;
  localparam int TMO    = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load_req = 1'b0;
  logic core_reset, load_done;
  logic [1:0] load_error;
  logic [ADDR_W:0] words_loaded;
  state_t dbg_state;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W+31:0] exp_q[$];
  logic [ADDR_W+31:0] exp_w;
  logic [31:0] data_words [DEPTH];

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .load_req     (load_req),
    .core_reset   (core_reset),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h required no write",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        exp_w = exp_q.pop_front();
        chk("imem_write", {bus.imem_addr, bus.imem_wdata}, exp_w);
      end
    end
  end

  // driver tasks (all driving at #1 after the rising edge)
  task automatic idle(input int n);
    bus.rx_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && guard < 64) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("handshake_ready", bus.rx_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    int g;
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8]);
      if (max_gap > 0) begin
        g = $urandom_range(0, max_gap);
        if (g > 0) idle(g);
      end
    end
  endtask

  task automatic check_status(input string tag, input bit done, input logic [1:0] err,
                              input int words);
    chk({tag, "_load_done"}, load_done, done);
    chk({tag, "_core_reset"}, core_reset, !done);
    chk({tag, "_load_error"}, load_error, err);
    chk({tag, "_words_loaded"}, words_loaded, words);
    chk({tag, "_rx_ready"}, bus.rx_ready, 1'b0);
    chk({tag, "_state"}, dbg_state, done ? DONE : ERR);
  endtask

  // Reference model: a frame's outcome follows from its length, its data
  // words and the modular sum of those words.
  task automatic run_frame(input int n, input logic [31:0] csum, input int max_gap,
                           input string tag);
    logic [31:0] sum = 32'd0;
    bit exp_done;
    logic [1:0] exp_err;
    int exp_words;
    if (n > DEPTH) begin
      exp_done = 1'b0;
      exp_err = 2'b01;
      exp_words = 0;
    end else begin
      for (int i = 0; i < n; i++) begin
        exp_q.push_back({8'(i), data_words[i]});
        sum = sum + data_words[i];
      end
      exp_words = n;
      exp_done = (sum == csum);
      exp_err = exp_done ? 2'b00 : 2'b10;
    end
    send_word(32'(n), max_gap);
    if (n <= DEPTH) begin
      for (int i = 0; i < n; i++) send_word(data_words[i], max_gap);
      send_word(csum, max_gap);
    end
    idle(2);
    check_status(tag, exp_done, exp_err, exp_words);
    chk({tag, "_writes_drained"}, exp_q.size(), 0);
  endtask

  task automatic reload(input bit with_byte);
    load_req = 1'b1;
    if (with_byte) begin
      bus.rx_data  = 8'h05;
      bus.rx_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    load_req = 1'b0;
    bus.rx_valid = 1'b0;
    chk("reload_core_reset", core_reset, 1'b1);
    chk("reload_load_done", load_done, 1'b0);
    chk("reload_load_error", load_error, 2'b00);
    chk("reload_words_loaded", words_loaded, 0);
    chk("reload_rx_ready", bus.rx_ready, 1'b1);
    chk("reload_state", dbg_state, HDR);
  endtask

  initial begin
    int n, g;
    logic [31:0] sum;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset values
    chk("rst_rx_ready", bus.rx_ready, 1'b1);
    chk("rst_imem_we", bus.imem_we, 1'b0);
    chk("rst_imem_addr", bus.imem_addr, 0);
    chk("rst_imem_wdata", bus.imem_wdata, 0);
    chk("rst_core_reset", core_reset, 1'b1);
    chk("rst_load_done", load_done, 1'b0);
    chk("rst_load_error", load_error, 2'b00);
    chk("rst_words_loaded", words_loaded, 0);
    chk("rst_state", dbg_state, HDR);

    // idle before the first byte never times out
    idle(100);
    chk("idle_hdr_error", load_error, 2'b00);
    chk("idle_hdr_state", dbg_state, HDR);

    // directed two-word program, good and bad checksum
    data_words[0] = 32'h00500093;
    data_words[1] = 32'h00A00113;
    run_frame(2, 32'h00F001A6, 0, "good2");
    reload(1'b0);
    run_frame(2, 32'h00F001A7, 0, "badcsum");
    reload(1'b0);

    // length just over the memory size
    run_frame(DEPTH + 1, 32'd0, 0, "len257");
    reload(1'b0);

    // empty program, then reload while a byte is offered
    run_frame(0, 32'd0, 0, "len0");
    reload(1'b1);

    // mid-frame timeout
    send_byte(8'h02);
    send_byte(8'h00);
    idle(14);
    chk("tmo_not_yet", load_error, 2'b00);
    idle(2);
    chk("tmo_error", load_error, 2'b11);
    chk("tmo_core_reset", core_reset, 1'b1);
    reload(1'b0);

    // reset on the cycle the first write strobe would appear
    send_word(32'd3, 0);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    #1;
    chk("midrst_imem_we", bus.imem_we, 1'b0);
    chk("midrst_state", dbg_state, HDR);
    chk("midrst_words", words_loaded, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) data_words[i] = $urandom();
    sum = data_words[0] + data_words[1] + data_words[2];
    run_frame(3, sum, 2, "after_rst");
    reload(1'b0);

    // randomized frames, gaps kept below the timeout
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(1, 12);
      g = $urandom_range(0, 3);
      sum = 32'd0;
      for (int i = 0; i < n; i++) begin
        data_words[i] = $urandom();
        sum = sum + data_words[i];
      end
      if ($urandom_range(0, 1) == 1) sum = sum ^ (32'd1 << $urandom_range(0, 31));
      run_frame(n, sum, g, $sformatf("rand%0d", f));
      reload($urandom_range(0, 1) == 1);
    end

    // full-depth program
    sum = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      data_words[i] = $urandom();
      sum = sum + data_words[i];
    end
    run_frame(DEPTH, sum, 0, "full");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader that sits directly upstream of the single-cycle core's instruction memory.
- Receives a framed little-endian byte stream over a valid/ready interface, assembles 32-bit words and writes them into instruction memory through a write port.
- Verifies a checksum, then releases the core from reset.
- Holds the core in reset while loading and after any load error.

Parameters:
- DEPTH, 256, instruction memory size in 32-bit words.
- ADDR_W, $clog2(DEPTH) = 8, word-address width.
- TIMEOUT_CYCLES, 1000000, mid-frame inter-byte timeout in clk cycles; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  8  stream byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader can accept a byte.
- load_req  in  1  single-cycle pulse: restart loading; honoured only in DONE or ERR.
- imem_we  out  1  instruction memory write strobe.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  32  word to write.
- core_reset  out  1  active-high reset to the core and its PC.
- load_done  out  1  program loaded and checksum OK.
- load_error  out  2  00 none, 01 length > DEPTH, 10 checksum mismatch, 11 timeout.
- words_loaded  out  ADDR_W+1  count of words written.

Behaviour:
- Frame format:
  - LEN: 4 bytes, little-endian word count N.
  - DATA: N words, 4 bytes each, LSB first.
  - CSUM: 4 bytes, expected sum of all data words mod 2^32.
- Reset values: state HDR, rx_ready 1, imem_we 0, imem_addr 0, imem_wdata 0, core_reset 1, load_done 0, load_error 00, words_loaded 0. All internal counters, the accumulator and the checksum are 0.
- Handshake:
  - A byte is accepted when rx_valid && rx_ready.
  - rx_ready = 1 in HDR, DATA and CSUM; 0 in DONE and ERR.
  - A 2-bit byte counter selects byte lane byte_cnt of the accumulator and wraps 3 -> 0.
- HDR:
  - On the 4th accepted byte, latch N.
  - N > DEPTH: go to ERR with code 01; no writes occur.
  - N == 0: go to CSUM.
  - Otherwise go to DATA.
- DATA:
  - On the 4th byte of a word, the next cycle drives imem_we = 1 for exactly one cycle, with imem_addr = word index and imem_wdata = the assembled word (latency 1).
  - In that same cycle: word index +1, words_loaded +1, checksum += word (mod 2^32).
  - After word N-1 is accepted, go to CSUM. Bytes may arrive back-to-back, one per cycle.
- CSUM:
  - On the 4th byte, compare the received value with the computed checksum.
  - Equal: go to DONE. Otherwise go to ERR with code 10.
  - N == 0 expects a checksum of 0.
- DONE: core_reset = 0 and load_done = 1, both registered (they change on the cycle the state enters DONE).
- ERR: core_reset stays 1, load_error holds its code, load_done = 0.
- Timeout:
  - The counter runs in HDR, DATA and CSUM only while mid-frame (any byte of the current frame already accepted). It clears on every accepted byte.
  - Reaching TIMEOUT_CYCLES goes to ERR with code 11.
  - Waiting idle in HDR before the first byte never times out.
- load_req:
  - In DONE or ERR: go to HDR, core_reset 1 on the next cycle. Clear load_done, load_error, words_loaded, all counters and the checksum.
  - Ignored in HDR, DATA and CSUM.
- Memory contents are not cleared by a reload; only the new N words are overwritten.
- reset asserted mid-load: immediate return to reset values, including any in-flight write strobe (imem_we 0).
- load_req and rx_valid in the same cycle in DONE: the byte is not accepted (rx_ready = 0).

Decomposition:
- Package imem_loader_pkg:
  - State enum {HDR, DATA, CSUM, DONE, ERR}.
  - Error code localparams ERR_NONE, ERR_LEN, ERR_CSUM, ERR_TIMEOUT.
- One sub-module, word_assembler: byte-to-word packing, 2-bit lane counter and word_valid pulse. It has its own clk/reset and a clear input.
- The FSM, checksum and timeout counter live in imem_loader.

Test Plan:
- Send LEN=2, words 0x00500093 and 0x00A00113, CSUM=0x00F001A6, all bytes back-to-back -> exactly two imem_we pulses: (addr 0, 0x00500093) then (addr 1, 0x00A00113). Then load_done=1, core_reset=0, words_loaded=2.
- Same frame with CSUM=0x00F001A7 -> load_error=10, core_reset stays 1, both words still written.
- Send LEN=257 with DEPTH=256 -> load_error=01 after the 4th byte, no imem_we, rx_ready=0.
- Send LEN=0 then CSUM=0 -> load_done=1 with no writes. Then pulse load_req -> core_reset=1, load_done=0, rx_ready=1 on the next cycle.
- With TIMEOUT_CYCLES=16: send 2 bytes of LEN, then idle 16 cycles -> load_error=11. Idle 100 cycles before the first byte -> no error.
- Assert reset mid-DATA at the cycle imem_we would pulse -> imem_we=0, state HDR. A subsequent full frame loads from addr 0 correctly.
